// File: rtl/ariane_axi.sv
// AXI channel and bundle types shared by the cache subsystem and the interconnect.
package ariane_axi;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } aw_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } ar_chan_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
  } w_chan_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } b_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } resp_t;

endpackage

// File: rtl/axi_txn_limiter.sv
// Caps outstanding AXI read/write bursts and reports idle/error status for fence and flush.
// Define AXI_TXN_LIMITER_STATS_EN to add per-channel stall cycle counters.
module axi_txn_limiter #(
  parameter int unsigned MAX_RD_TXN = 8,
  parameter int unsigned MAX_WR_TXN = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              drain_i,
  input  ariane_axi::req_t  slv_req_i,
  output ariane_axi::resp_t slv_resp_o,
  output ariane_axi::req_t  mst_req_o,
  input  ariane_axi::resp_t mst_resp_i,
  output logic [7:0]        rd_outstanding_o,
  output logic [7:0]        wr_outstanding_o,
  output logic              idle_o,
  output logic              err_o,
  input  logic              err_clr_i
`ifdef AXI_TXN_LIMITER_STATS_EN
  ,
  output logic [31:0]       rd_stall_cnt_o,
  output logic [31:0]       wr_stall_cnt_o
`endif
);

  localparam logic [1:0] ST_OPEN  = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_BLOCK = 2'd2;

  localparam logic [7:0] RD_MAX = MAX_RD_TXN[7:0];
  localparam logic [7:0] WR_MAX = MAX_WR_TXN[7:0];

  logic [1:0] ar_state_q, ar_state_d, aw_state_q, aw_state_d;
  logic [7:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic       err_q, idle_q;
  logic       rd_limit, wr_limit, ar_hold, aw_hold, ar_blocked, aw_blocked;
  logic       ar_hs, aw_hs, r_hs, r_last_hs, b_hs;
  logic       rd_underflow, wr_underflow, err_set;

  // A presented-but-unaccepted request is never withdrawn, so HOLD overrides any gating.
  function automatic logic [1:0] fsm_next(input logic [1:0] st, input logic limit,
                                          input logic valid, input logic ready);
    logic [1:0] nxt;
    if (st == ST_HOLD)       nxt = ready ? ST_OPEN : ST_HOLD;
    else if (limit)          nxt = ST_BLOCK;
    else if (valid && !ready) nxt = ST_HOLD;
    else                     nxt = ST_OPEN;
    return nxt;
  endfunction

  function automatic logic [7:0] cnt_next(input logic [7:0] cnt, input logic inc, input logic dec);
    logic [7:0] nxt;
    nxt = cnt;
    if (inc && !dec && cnt != 8'hFF)   nxt = cnt + 8'd1;
    else if (dec && !inc && cnt != 8'h00) nxt = cnt - 8'd1;
    return nxt;
  endfunction

  assign rd_limit   = drain_i | (rd_cnt_q == RD_MAX);
  assign wr_limit   = drain_i | (wr_cnt_q == WR_MAX);
  assign ar_hold    = (ar_state_q == ST_HOLD);
  assign aw_hold    = (aw_state_q == ST_HOLD);
  assign ar_blocked = ~ar_hold & rd_limit;
  assign aw_blocked = ~aw_hold & wr_limit;

  always_comb begin
    mst_req_o          = slv_req_i;
    mst_req_o.ar_valid = ar_hold | (slv_req_i.ar_valid & ~ar_blocked);
    mst_req_o.aw_valid = aw_hold | (slv_req_i.aw_valid & ~aw_blocked);
    slv_resp_o          = mst_resp_i;
    slv_resp_o.ar_ready = mst_resp_i.ar_ready & ~ar_blocked;
    slv_resp_o.aw_ready = mst_resp_i.aw_ready & ~aw_blocked;
  end

  assign ar_hs     = mst_req_o.ar_valid & mst_resp_i.ar_ready;
  assign aw_hs     = mst_req_o.aw_valid & mst_resp_i.aw_ready;
  assign r_hs      = mst_resp_i.r_valid & slv_req_i.r_ready;
  assign r_last_hs = r_hs & mst_resp_i.r.last;
  assign b_hs      = mst_resp_i.b_valid & slv_req_i.b_ready;

  assign rd_underflow = r_last_hs & ~ar_hs & (rd_cnt_q == 8'h00);
  assign wr_underflow = b_hs & ~aw_hs & (wr_cnt_q == 8'h00);
  assign err_set = rd_underflow | wr_underflow
                 | (r_hs & mst_resp_i.r.resp[1]) | (b_hs & mst_resp_i.b.resp[1]);

  assign ar_state_d = fsm_next(ar_state_q, rd_limit, slv_req_i.ar_valid, mst_resp_i.ar_ready);
  assign aw_state_d = fsm_next(aw_state_q, wr_limit, slv_req_i.aw_valid, mst_resp_i.aw_ready);
  assign rd_cnt_d   = cnt_next(rd_cnt_q, ar_hs, r_last_hs);
  assign wr_cnt_d   = cnt_next(wr_cnt_q, aw_hs, b_hs);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ar_state_q <= ST_OPEN;
      aw_state_q <= ST_OPEN;
      rd_cnt_q   <= 8'h00;
      wr_cnt_q   <= 8'h00;
      err_q      <= 1'b0;
      idle_q     <= 1'b1;
    end else begin
      ar_state_q <= ar_state_d;
      aw_state_q <= aw_state_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      err_q      <= err_set | (err_q & ~err_clr_i);
      idle_q     <= (rd_cnt_q == 8'h00) & (wr_cnt_q == 8'h00) & ~ar_hold & ~aw_hold;
    end
  end

  assign rd_outstanding_o = rd_cnt_q;
  assign wr_outstanding_o = wr_cnt_q;
  assign idle_o           = idle_q;
  assign err_o            = err_q;

`ifdef AXI_TXN_LIMITER_STATS_EN
  logic [31:0] rd_stall_q, wr_stall_q;

  // Stall cycles accumulate while the cache is asking but the limiter refuses it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_stall_q <= 32'h0;
      wr_stall_q <= 32'h0;
    end else if (err_clr_i) begin
      rd_stall_q <= 32'h0;
      wr_stall_q <= 32'h0;
    end else begin
      if (slv_req_i.ar_valid && ar_blocked && rd_stall_q != 32'hFFFF_FFFF)
        rd_stall_q <= rd_stall_q + 32'd1;
      if (slv_req_i.aw_valid && aw_blocked && wr_stall_q != 32'hFFFF_FFFF)
        wr_stall_q <= wr_stall_q + 32'd1;
    end
  end

  assign rd_stall_cnt_o = rd_stall_q;
  assign wr_stall_cnt_o = wr_stall_q;
`endif

endmodule

// File: tb/tb_axi_txn_limiter.sv
// Directed bench for axi_txn_limiter: a transaction-level model is compared every cycle,
// and literal checks pin the model at the scenario boundaries.
module tb_axi_txn_limiter;

  localparam int MAX_RD = 2;
  localparam int MAX_WR = 4;

  logic clk_i = 1'b0;
  logic rst_ni, drain_i, err_clr_i;
  ariane_axi::req_t  slv_req, mst_req, exp_req;
  ariane_axi::resp_t slv_resp, mst_resp, exp_resp;
  logic [7:0] rd_out, wr_out;
  logic       idle, err;
`ifdef AXI_TXN_LIMITER_STATS_EN
  logic [31:0] rd_stall, wr_stall;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  int      m_rd, m_wr;
  bit      m_err, m_idle, m_ar_hold, m_aw_hold;
  longint  m_rd_stall, m_wr_stall;
  bit      ar_open, aw_open;

  always #5 clk_i = ~clk_i;

  axi_txn_limiter #(.MAX_RD_TXN(MAX_RD), .MAX_WR_TXN(MAX_WR)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .drain_i          (drain_i),
    .slv_req_i        (slv_req),
    .slv_resp_o       (slv_resp),
    .mst_req_o        (mst_req),
    .mst_resp_i       (mst_resp),
    .rd_outstanding_o (rd_out),
    .wr_outstanding_o (wr_out),
    .idle_o           (idle),
    .err_o            (err),
    .err_clr_i        (err_clr_i)
`ifdef AXI_TXN_LIMITER_STATS_EN
    ,
    .rd_stall_cnt_o   (rd_stall),
    .wr_stall_cnt_o   (wr_stall)
`endif
  );

  // Model view: a channel may issue when it is finishing a held request, or when
  // there is no drain and fewer than the maximum bursts are outstanding.
  always_comb begin
    ar_open = m_ar_hold || (!drain_i && m_rd < MAX_RD);
    aw_open = m_aw_hold || (!drain_i && m_wr < MAX_WR);
    exp_req = slv_req;
    exp_req.ar_valid = m_ar_hold ? 1'b1 : (slv_req.ar_valid && ar_open);
    exp_req.aw_valid = m_aw_hold ? 1'b1 : (slv_req.aw_valid && aw_open);
    exp_resp = mst_resp;
    exp_resp.ar_ready = ar_open && mst_resp.ar_ready;
    exp_resp.aw_ready = aw_open && mst_resp.aw_ready;
  end

  always @(posedge clk_i or negedge rst_ni) begin : model
    bit ar_v, aw_v, ar_hs, aw_hs, r_hs, rl, b_hs, set, ar_o, aw_o;
    if (!rst_ni) begin
      m_rd = 0; m_wr = 0; m_err = 0; m_idle = 1;
      m_ar_hold = 0; m_aw_hold = 0; m_rd_stall = 0; m_wr_stall = 0;
    end else begin
      ar_v  = exp_req.ar_valid;
      aw_v  = exp_req.aw_valid;
      ar_o  = ar_open;
      aw_o  = aw_open;
      ar_hs = ar_v && mst_resp.ar_ready;
      aw_hs = aw_v && mst_resp.aw_ready;
      r_hs  = mst_resp.r_valid && slv_req.r_ready;
      rl    = r_hs && mst_resp.r.last;
      b_hs  = mst_resp.b_valid && slv_req.b_ready;
      set   = (r_hs && mst_resp.r.resp[1]) || (b_hs && mst_resp.b.resp[1]);
      m_idle = (m_rd == 0) && (m_wr == 0) && !m_ar_hold && !m_aw_hold;
      if (ar_hs && !rl) m_rd = (m_rd < 255) ? m_rd + 1 : m_rd;
      else if (rl && !ar_hs) begin
        if (m_rd == 0) set = 1; else m_rd = m_rd - 1;
      end
      if (aw_hs && !b_hs) m_wr = (m_wr < 255) ? m_wr + 1 : m_wr;
      else if (b_hs && !aw_hs) begin
        if (m_wr == 0) set = 1; else m_wr = m_wr - 1;
      end
      m_ar_hold = ar_v && !mst_resp.ar_ready;
      m_aw_hold = aw_v && !mst_resp.aw_ready;
      m_err = set ? 1'b1 : (err_clr_i ? 1'b0 : m_err);
      if (err_clr_i) begin
        m_rd_stall = 0; m_wr_stall = 0;
      end else begin
        if (slv_req.ar_valid && !ar_o && m_rd_stall < 64'hFFFF_FFFF) m_rd_stall++;
        if (slv_req.aw_valid && !aw_o && m_wr_stall < 64'hFFFF_FFFF) m_wr_stall++;
      end
    end
  end

  task automatic check_output(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk_i) begin
    check_output("mst_req", mst_req, exp_req);
    check_output("slv_resp", slv_resp, exp_resp);
    check_output("rd_outstanding", rd_out, 8'(m_rd));
    check_output("wr_outstanding", wr_out, 8'(m_wr));
    check_output("idle", idle, m_idle);
    check_output("err", err, m_err);
`ifdef AXI_TXN_LIMITER_STATS_EN
    check_output("rd_stall_cnt", rd_stall, 32'(m_rd_stall));
    check_output("wr_stall_cnt", wr_stall, 32'(m_wr_stall));
`endif
  end

  task automatic apply_stimulus(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  initial begin
    rst_ni = 1'b0; drain_i = 1'b0; err_clr_i = 1'b0;
    slv_req = '0; mst_resp = '0;
    slv_req.r_ready = 1'b1;
    slv_req.b_ready = 1'b1;
    apply_stimulus(2);
    check_output("reset rd", rd_out, 8'd0);
    check_output("reset wr", wr_out, 8'd0);
    check_output("reset idle", idle, 1'b1);
    check_output("reset err", err, 1'b0);
    check_output("reset mst ar_valid", mst_req.ar_valid, 1'b0);
    check_output("reset mst aw_valid", mst_req.aw_valid, 1'b0);
    rst_ni = 1'b1;
    apply_stimulus(1);

    // Read limit: two accepted, third stalls until an R-last frees a slot.
    mst_resp.ar_ready = 1'b1;
    slv_req.ar_valid = 1'b1; slv_req.ar.addr = 32'h1000;
    apply_stimulus(1);
    slv_req.ar.addr = 32'h2000;
    apply_stimulus(1);
    slv_req.ar.addr = 32'h3000;
    check_output("limit rd count", rd_out, 8'd2);
    check_output("limit slv ar_ready", slv_resp.ar_ready, 1'b0);
    check_output("limit mst ar_valid", mst_req.ar_valid, 1'b0);
    apply_stimulus(2);
    mst_resp.r_valid = 1'b1; mst_resp.r.last = 1'b1;
    apply_stimulus(1);
    mst_resp.r_valid = 1'b0;
    check_output("freed rd count", rd_out, 8'd1);
    check_output("freed slv ar_ready", slv_resp.ar_ready, 1'b1);
    apply_stimulus(1);
    check_output("refill rd count", rd_out, 8'd2);
    slv_req.ar_valid = 1'b0;
    mst_resp.r_valid = 1'b1;
    apply_stimulus(2);
    mst_resp.r_valid = 1'b0;
    apply_stimulus(1);
    check_output("drained rd count", rd_out, 8'd0);
    check_output("drained idle", idle, 1'b1);

    // A held AR survives a drain request, then the channel blocks.
    mst_resp.ar_ready = 1'b0;
    slv_req.ar_valid = 1'b1; slv_req.ar.addr = 32'h4000;
    apply_stimulus(1);
    drain_i = 1'b1;
    check_output("hold ar_valid under drain", mst_req.ar_valid, 1'b1);
    apply_stimulus(2);
    check_output("hold ar_valid later", mst_req.ar_valid, 1'b1);
    check_output("hold idle", idle, 1'b0);
    mst_resp.ar_ready = 1'b1;
    apply_stimulus(1);
    check_output("hold counted", rd_out, 8'd1);
    check_output("drain blocks ar_valid", mst_req.ar_valid, 1'b0);
    check_output("drain blocks ar_ready", slv_resp.ar_ready, 1'b0);
    slv_req.ar_valid = 1'b0;
    mst_resp.r_valid = 1'b1;
    apply_stimulus(1);
    mst_resp.r_valid = 1'b0;
    check_output("idle lags count", idle, 1'b0);
    apply_stimulus(1);
    check_output("idle after drain", idle, 1'b1);
    drain_i = 1'b0;

    // Simultaneous AW and B leave the write count unchanged.
    mst_resp.aw_ready = 1'b1;
    slv_req.aw_valid = 1'b1;
    apply_stimulus(3);
    mst_resp.b_valid = 1'b1;
    apply_stimulus(1);
    check_output("aw+b same cycle", wr_out, 8'd3);
    slv_req.aw_valid = 1'b0;
    mst_resp.b.resp = 2'b10;
    apply_stimulus(1);
    mst_resp.b.resp = 2'b00;
    mst_resp.b_valid = 1'b0;
    check_output("slverr sets err", err, 1'b1);
    check_output("slverr wr count", wr_out, 8'd2);
    err_clr_i = 1'b1;
    apply_stimulus(1);
    err_clr_i = 1'b0;
    check_output("err cleared", err, 1'b0);
    mst_resp.b_valid = 1'b1;
    apply_stimulus(2);
    check_output("wr drained", wr_out, 8'd0);
    apply_stimulus(1);
    check_output("underflow err", err, 1'b1);
    check_output("underflow count", wr_out, 8'd0);
    mst_resp.b.resp = 2'b11; err_clr_i = 1'b1;
    apply_stimulus(1);
    check_output("set beats clear", err, 1'b1);
    mst_resp.b_valid = 1'b0; mst_resp.b.resp = 2'b00;
    apply_stimulus(1);
    err_clr_i = 1'b0;
    check_output("err cleared again", err, 1'b0);

    // 4-beat burst: only the last beat retires it; then reset mid-burst.
    slv_req.ar_valid = 1'b1; slv_req.ar.len = 8'd3;
    apply_stimulus(1);
    slv_req.ar_valid = 1'b0;
    mst_resp.r_valid = 1'b1; mst_resp.r.last = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mst_resp.r.data = 64'(i);
      apply_stimulus(1);
      check_output("burst mid-beat count", rd_out, 8'd1);
    end
    mst_resp.r.last = 1'b1;
    apply_stimulus(1);
    check_output("burst last beat", rd_out, 8'd0);
    mst_resp.r_valid = 1'b0;
    slv_req.ar_valid = 1'b1;
    apply_stimulus(1);
    slv_req.ar_valid = 1'b0;
    mst_resp.r_valid = 1'b1; mst_resp.r.last = 1'b0; mst_resp.r.resp = 2'b10;
    apply_stimulus(1);
    mst_resp.r.resp = 2'b00;
    check_output("burst 2 count", rd_out, 8'd1);
    check_output("burst slverr", err, 1'b1);
    #2 rst_ni = 1'b0;
    #1;
    check_output("midburst reset rd", rd_out, 8'd0);
    check_output("midburst reset idle", idle, 1'b1);
    check_output("midburst reset err", err, 1'b0);
    mst_resp.r_valid = 1'b0;
    apply_stimulus(1);
    rst_ni = 1'b1;
    apply_stimulus(1);

`ifdef AXI_TXN_LIMITER_STATS_EN
    slv_req.aw_valid = 1'b1;
    apply_stimulus(MAX_WR);
    apply_stimulus(5);
    check_output("wr full", wr_out, 8'(MAX_WR));
    check_output("wr stall cycles", wr_stall, 32'd5);
    slv_req.aw_valid = 1'b0;
    err_clr_i = 1'b1;
    apply_stimulus(1);
    err_clr_i = 1'b0;
    check_output("stall cleared", wr_stall, 32'd0);
`endif

    apply_stimulus(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
